// File: rtl/sdram_arbit.sv
// ---------------------------------------------------------------------------
// sdram_arbit
//
// Command arbiter and pin multiplexer for the SDRAM controller. After the
// init sequence it hands the shared command/address/data pins to exactly
// one sub-controller at a time: refresh first, then write, then read. A
// write-streak counter lets a pending read win over write after WR_MAX
// back-to-back write grants, so the display read path is never starved.
//
// Ports
//   sys_clk, sys_rst_n        clock, asynchronous active-low reset
//   init_*                    init sequencer command bus and done level
//   aref_req/aref_end/aref_*  refresh request, done pulse, command bus
//   wr_req/wr_end/wr_*        write request, done pulse, command bus
//   wr_sdram_en/wr_sdram_data write data and its drive enable
//   rd_req/rd_end/rd_*        read request, done pulse, command bus
//   aref_en/wr_en/rd_en       grants, decoded from the registered state
//   sdram_*                   SDRAM pins (cke, command, bank, address, dq)
// ---------------------------------------------------------------------------
module sdram_arbit #(
    parameter int unsigned WR_MAX  = 4,
    parameter logic [3:0]  CMD_NOP = 4'b0111
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [3:0]  init_cmd,
    input  logic [1:0]  init_ba,
    input  logic [12:0] init_addr,
    input  logic        init_end,
    input  logic        aref_req,
    input  logic        aref_end,
    input  logic [3:0]  aref_cmd,
    input  logic [1:0]  aref_ba,
    input  logic [12:0] aref_addr,
    input  logic        wr_req,
    input  logic        wr_end,
    input  logic [3:0]  wr_cmd,
    input  logic [1:0]  wr_ba,
    input  logic [12:0] wr_addr,
    input  logic        wr_sdram_en,
    input  logic [15:0] wr_sdram_data,
    input  logic        rd_req,
    input  logic        rd_end,
    input  logic [3:0]  rd_cmd,
    input  logic [1:0]  rd_ba,
    input  logic [12:0] rd_addr,
    output logic        aref_en,
    output logic        wr_en,
    output logic        rd_en,
    output logic        sdram_cke,
    output logic        sdram_cs_n,
    output logic        sdram_ras_n,
    output logic        sdram_cas_n,
    output logic        sdram_we_n,
    output logic [1:0]  sdram_ba,
    output logic [12:0] sdram_addr,
    inout  wire  [15:0] sdram_dq
);

    typedef enum logic [2:0] {
        IDLE,
        ARBIT,
        AREF,
        WRITE,
        READ
    } state_t;

    localparam logic [3:0] WR_MAX_L = WR_MAX[3:0];

    state_t      state_q, state_d;
    logic [3:0]  wrStreak_q, wrStreak_d;
    logic [3:0]  pinCmd;

    // State and write-streak registers. Reset drops straight back to IDLE
    // so the init bus owns the pins even in the middle of a burst.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            wrStreak_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            wrStreak_q <= wrStreak_d;
        end
    end

    // Next-state and streak logic. The streak only counts writes granted
    // while a read is waiting; a write won with no read pending restarts it
    // at zero. Refresh leaves it untouched.
    always_comb begin
        state_d    = state_q;
        wrStreak_d = wrStreak_q;
        case (state_q)
            IDLE: begin
                if (init_end) begin
                    state_d = ARBIT;
                end
            end
            ARBIT: begin
                if (aref_req) begin
                    state_d = AREF;
                end else if (rd_req && (wrStreak_q >= WR_MAX_L)) begin
                    state_d    = READ;
                    wrStreak_d = 4'd0;
                end else if (wr_req) begin
                    state_d = WRITE;
                    if (!rd_req) begin
                        wrStreak_d = 4'd0;
                    end else if (wrStreak_q != 4'hf) begin
                        wrStreak_d = wrStreak_q + 4'd1;
                    end
                end else if (rd_req) begin
                    state_d    = READ;
                    wrStreak_d = 4'd0;
                end else begin
                    wrStreak_d = 4'd0;
                end
            end
            AREF: begin
                if (aref_end) begin
                    state_d = ARBIT;
                end
            end
            WRITE: begin
                if (wr_end) begin
                    state_d = ARBIT;
                end
            end
            READ: begin
                if (rd_end) begin
                    state_d = ARBIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pin multiplexer: the owner's bus passes through combinationally, so
    // a sub-controller sees its own command on the pins in the same cycle.
    always_comb begin
        pinCmd     = init_cmd;
        sdram_ba   = init_ba;
        sdram_addr = init_addr;
        case (state_q)
            ARBIT: begin
                pinCmd     = CMD_NOP;
                sdram_ba   = 2'b11;
                sdram_addr = 13'h1fff;
            end
            AREF: begin
                pinCmd     = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            WRITE: begin
                pinCmd     = wr_cmd;
                sdram_ba   = wr_ba;
                sdram_addr = wr_addr;
            end
            READ: begin
                pinCmd     = rd_cmd;
                sdram_ba   = rd_ba;
                sdram_addr = rd_addr;
            end
            default: begin
                pinCmd     = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = pinCmd;

    assign aref_en   = (state_q == AREF);
    assign wr_en     = (state_q == WRITE);
    assign rd_en     = (state_q == READ);
    assign sdram_cke = 1'b1;

    // The data bus is only ever driven by an active write burst.
    assign sdram_dq = ((state_q == WRITE) && wr_sdram_en) ? wr_sdram_data : 16'hzzzz;

endmodule

// File: tb/tb_sdram_arbit.sv
// ---------------------------------------------------------------------------
// tb_sdram_arbit
//
// Directed bench for sdram_arbit: a table of per-cycle request/end vectors
// with the expected arbiter state after each clock, followed by hand-written
// sequences for the write-streak limit, the data bus drive rules and a reset
// arriving in the middle of a read burst.
// ---------------------------------------------------------------------------
module tb_sdram_arbit;

    localparam int S_IDLE  = 0;
    localparam int S_ARBIT = 1;
    localparam int S_AREF  = 2;
    localparam int S_WRITE = 3;
    localparam int S_READ  = 4;

    typedef struct {
        logic ie;
        logic ar;
        logic ae;
        logic wq;
        logic we;
        logic rq;
        logic re;
        int   expState;
    } vector_t;

    logic        sysClk = 1'b0;
    logic        sysRstN;
    logic [3:0]  initCmd;
    logic [1:0]  initBa;
    logic [12:0] initAddr;
    logic        initEnd;
    logic        arefReq;
    logic        arefEnd;
    logic [3:0]  arefCmd;
    logic [1:0]  arefBa;
    logic [12:0] arefAddr;
    logic        wrReq;
    logic        wrEnd;
    logic [3:0]  wrCmd;
    logic [1:0]  wrBa;
    logic [12:0] wrAddr;
    logic        wrSdramEn;
    logic [15:0] wrSdramData;
    logic        rdReq;
    logic        rdEnd;
    logic [3:0]  rdCmd;
    logic [1:0]  rdBa;
    logic [12:0] rdAddr;
    logic        arefEn;
    logic        wrEn;
    logic        rdEn;
    logic        sdramCke;
    logic        sdramCsN;
    logic        sdramRasN;
    logic        sdramCasN;
    logic        sdramWeN;
    logic [1:0]  sdramBa;
    logic [12:0] sdramAddr;
    wire  [15:0] sdramDq;
    logic        tbDqEn;
    logic [15:0] tbDqVal;

    int testsRun  = 0;
    int failCount = 0;
    vector_t vecs[$];

    assign sdramDq = tbDqEn ? tbDqVal : 16'hzzzz;

    always #5 sysClk = ~sysClk;

    sdram_arbit #(
        .WR_MAX  (4),
        .CMD_NOP (4'b0111)
    ) dut (
        .sys_clk       (sysClk),
        .sys_rst_n     (sysRstN),
        .init_cmd      (initCmd),
        .init_ba       (initBa),
        .init_addr     (initAddr),
        .init_end      (initEnd),
        .aref_req      (arefReq),
        .aref_end      (arefEnd),
        .aref_cmd      (arefCmd),
        .aref_ba       (arefBa),
        .aref_addr     (arefAddr),
        .wr_req        (wrReq),
        .wr_end        (wrEnd),
        .wr_cmd        (wrCmd),
        .wr_ba         (wrBa),
        .wr_addr       (wrAddr),
        .wr_sdram_en   (wrSdramEn),
        .wr_sdram_data (wrSdramData),
        .rd_req        (rdReq),
        .rd_end        (rdEnd),
        .rd_cmd        (rdCmd),
        .rd_ba         (rdBa),
        .rd_addr       (rdAddr),
        .aref_en       (arefEn),
        .wr_en         (wrEn),
        .rd_en         (rdEn),
        .sdram_cke     (sdramCke),
        .sdram_cs_n    (sdramCsN),
        .sdram_ras_n   (sdramRasN),
        .sdram_cas_n   (sdramCasN),
        .sdram_we_n    (sdramWeN),
        .sdram_ba      (sdramBa),
        .sdram_addr    (sdramAddr),
        .sdram_dq      (sdramDq)
    );

    // Expected {cmd, ba, addr} on the pins for each state, using the fixed
    // sub-controller buses driven below.
    function automatic logic [18:0] expPins(input int s);
        case (s)
            S_ARBIT: return {4'b0111, 2'b11, 13'h1fff};
            S_AREF:  return {4'b0001, 2'b00, 13'h0400};
            S_WRITE: return {4'b0100, 2'b10, 13'h0123};
            S_READ:  return {4'b0101, 2'b11, 13'h0456};
            default: return {4'b0010, 2'b01, 13'h0aaa};
        endcase
    endfunction

    // Expected {aref_en, wr_en, rd_en} for each state.
    function automatic logic [2:0] expGrant(input int s);
        case (s)
            S_AREF:  return 3'b100;
            S_WRITE: return 3'b010;
            S_READ:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic vector_t mk(input logic ie, input logic ar, input logic ae,
                                   input logic wq, input logic we, input logic rq,
                                   input logic re, input int s);
        vector_t v;
        v.ie = ie; v.ar = ar; v.ae = ae; v.wq = wq;
        v.we = we; v.rq = rq; v.re = re; v.expState = s;
        return v;
    endfunction

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic applyStimulus(input vector_t v);
        initEnd = v.ie;
        arefReq = v.ar;
        arefEnd = v.ae;
        wrReq   = v.wq;
        wrEnd   = v.we;
        rdReq   = v.rq;
        rdEnd   = v.re;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic checkState(input string tag, input int s);
        checkOutput({tag, " grants"}, {29'd0, arefEn, wrEn, rdEn}, {29'd0, expGrant(s)});
        checkOutput({tag, " pins"},
                    {13'd0, sdramCsN, sdramRasN, sdramCasN, sdramWeN, sdramBa, sdramAddr},
                    {13'd0, expPins(s)});
    endtask

    // Hand-computed cycle table: each row's inputs are held for one clock,
    // expState is the state expected just after that clock.
    initial begin
        logic [2:0] streakExp [10];
        streakExp = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b001,
                      3'b010, 3'b010, 3'b010, 3'b010, 3'b001};

        sysRstN     = 1'b0;
        initCmd     = 4'b0010; initBa = 2'b01; initAddr = 13'h0aaa;
        arefCmd     = 4'b0001; arefBa = 2'b00; arefAddr = 13'h0400;
        wrCmd       = 4'b0100; wrBa   = 2'b10; wrAddr   = 13'h0123;
        rdCmd       = 4'b0101; rdBa   = 2'b11; rdAddr   = 13'h0456;
        wrSdramEn   = 1'b0;
        wrSdramData = 16'ha5a5;
        tbDqEn      = 1'b0;
        tbDqVal     = 16'h1234;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, S_IDLE));

        for (int i = 0; i < 9; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, S_IDLE));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, S_ARBIT));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, S_ARBIT));
        vecs.push_back(mk(0, 1, 0, 1, 0, 1, 0, S_AREF));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, S_AREF));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, S_ARBIT));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 0, 1, 0, 1, 1, S_WRITE));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 0, 1, 1, 1, 0, S_ARBIT));
        vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, S_READ));
        vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, S_READ));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, S_ARBIT));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, S_ARBIT));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, S_WRITE));
        vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, S_ARBIT));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, S_AREF));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, S_ARBIT));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, S_ARBIT));

        #2;
        checkState("reset", S_IDLE);
        checkOutput("reset cke", {31'd0, sdramCke}, 32'd1);
        tick();
        tick();
        sysRstN = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            tick();
            checkState($sformatf("vec%0d", i), vecs[i].expState);
        end
        checkOutput("cke after init", {31'd0, sdramCke}, 32'd1);

        // Both write and read held, every burst closed after 8 cycles.
        applyStimulus(mk(0, 0, 0, 1, 0, 1, 0, S_ARBIT));
        for (int g = 0; g < 10; g++) begin
            tick();
            checkOutput($sformatf("streak grant %0d", g), {29'd0, arefEn, wrEn, rdEn},
                        {29'd0, streakExp[g]});
            if (g == 0) begin
                wrSdramEn = 1'b1;
                #1;
                checkOutput("dq write drive", {16'd0, sdramDq}, 32'h0000a5a5);
                wrSdramEn = 1'b0;
                tbDqEn    = 1'b1;
                #1;
                checkOutput("dq write disabled", {16'd0, sdramDq}, 32'h00001234);
                tbDqEn    = 1'b0;
                checkState("streak write", S_WRITE);
            end
            if (g == 4) begin
                wrSdramEn = 1'b1;
                tbDqEn    = 1'b1;
                #1;
                checkOutput("dq in read", {16'd0, sdramDq}, 32'h00001234);
                wrSdramEn = 1'b0;
                tbDqEn    = 1'b0;
                checkState("streak read", S_READ);
            end
            for (int c = 2; c <= 8; c++) tick();
            checkOutput($sformatf("streak hold %0d", g), {29'd0, arefEn, wrEn, rdEn},
                        {29'd0, streakExp[g]});
            if (streakExp[g] == 3'b010) wrEnd = 1'b1;
            else                         rdEnd = 1'b1;
            tick();
            wrEnd = 1'b0;
            rdEnd = 1'b0;
            checkState($sformatf("streak gap %0d", g), S_ARBIT);
        end

        // Reset lands in the middle of a read burst.
        applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, S_READ));
        tick();
        checkState("pre-reset read", S_READ);
        tick();
        sysRstN   = 1'b0;
        wrSdramEn = 1'b1;
        tbDqEn    = 1'b1;
        #1;
        checkState("reset mid-read", S_IDLE);
        checkOutput("dq in reset", {16'd0, sdramDq}, 32'h00001234);
        checkOutput("cke in reset", {31'd0, sdramCke}, 32'd1);
        wrSdramEn = 1'b0;
        tbDqEn    = 1'b0;
        tick();
        tick();
        sysRstN = 1'b1;
        applyStimulus(mk(0, 1, 0, 1, 0, 1, 0, S_IDLE));
        for (int k = 0; k < 3; k++) begin
            tick();
            checkState($sformatf("post-reset idle %0d", k), S_IDLE);
        end
        applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, S_ARBIT));
        tick();
        checkState("re-init", S_ARBIT);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
